// File: rtl/logisim_tick_controller.sv
// Run/halt/single-step sequencer with a reloadable period down-counter.
// Optional ticks-emitted counter on TickCount when TICK_COUNTER_EN is defined.
module logisim_tick_controller #(
    parameter int NrOfBits      = 16,
    parameter int DefaultReload = 1000
) (
    input  logic                FPGAClock,
    input  logic                FPGAReset_n,
    input  logic                Run,
    input  logic                StepReq,
    input  logic                ReloadLoad,
    input  logic [NrOfBits-1:0] ReloadValue,
    input  logic                ClearCount,
    output logic                FPGATick,
    output logic                Running,
    output logic                StepDone,
    output logic [31:0]         TickCount
);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam logic [NrOfBits-1:0] ONE = NrOfBits'(1);
    localparam logic [NrOfBits-1:0] DEF_TRUNC = NrOfBits'(DefaultReload);
    localparam logic [NrOfBits-1:0] DEF_PERIOD =
        (DEF_TRUNC == '0) ? ONE : DEF_TRUNC;

    state_t              state, state_next;
    logic [NrOfBits-1:0] count, count_next;
    logic [NrOfBits-1:0] period, period_next;
    logic [NrOfBits-1:0] pend_val, pend_val_next;
    logic                pend, pend_next;
    logic                tick_next, done_next;
    logic                at_zero;
    logic [NrOfBits-1:0] load_eff;

    assign at_zero  = (count == '0);
    assign load_eff = (ReloadValue == '0) ? ONE : ReloadValue;

    always_comb begin
        state_next    = state;
        count_next    = count;
        period_next   = period;
        pend_val_next = pend_val;
        pend_next     = pend;
        tick_next     = 1'b0;
        done_next     = 1'b0;

        unique case (state)
            HALT: begin
                count_next = '0;
                if (pend) begin
                    period_next = pend_val;
                    pend_next   = 1'b0;
                end
                if (Run) begin
                    state_next = RUN;
                end else if (StepReq) begin
                    state_next = STEP;
                end
            end
            RUN, STEP: begin
                tick_next = at_zero;
                done_next = (state == STEP) && at_zero;
                if (at_zero) begin
                    // a pending period only takes effect on a boundary
                    if (pend) begin
                        period_next = pend_val;
                        pend_next   = 1'b0;
                        count_next  = pend_val - ONE;
                    end else begin
                        count_next = period - ONE;
                    end
                end else begin
                    count_next = count - ONE;
                end
                if (state == STEP) begin
                    state_next = Run ? RUN : HALT;
                end else if (!Run) begin
                    state_next = HALT;
                end
                if (state_next == HALT) begin
                    count_next = '0;
                end
            end
            default: begin
                state_next = HALT;
                count_next = '0;
            end
        endcase

        // a fresh capture outranks an application in the same cycle
        if (ReloadLoad) begin
            pend_val_next = load_eff;
            pend_next     = 1'b1;
        end
    end

    always_ff @(posedge FPGAClock or negedge FPGAReset_n) begin
        if (!FPGAReset_n) begin
            state    <= HALT;
            count    <= '0;
            period   <= DEF_PERIOD;
            pend_val <= DEF_PERIOD;
            pend     <= 1'b0;
            FPGATick <= 1'b0;
            StepDone <= 1'b0;
            Running  <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            period   <= period_next;
            pend_val <= pend_val_next;
            pend     <= pend_next;
            FPGATick <= tick_next;
            StepDone <= done_next;
            Running  <= (state_next == RUN);
        end
    end

`ifdef TICK_COUNTER_EN
    logic [31:0] tick_cnt;

    always_ff @(posedge FPGAClock or negedge FPGAReset_n) begin
        if (!FPGAReset_n) begin
            tick_cnt <= '0;
        end else if (ClearCount) begin
            tick_cnt <= '0;
        end else if (FPGATick) begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end

    assign TickCount = tick_cnt;
`else
    logic unused_clear;

    assign unused_clear = ClearCount;
    assign TickCount    = '0;
`endif

endmodule

// File: tb/tb_logisim_tick_controller.sv
// Vector-table bench for logisim_tick_controller (DefaultReload=4),
// with hand-written async-reset and tick-spacing sequences.
module tb_logisim_tick_controller;

    localparam int NB  = 16;
    localparam int DEF = 4;
`ifdef TICK_COUNTER_EN
    localparam bit TC_EN = 1'b1;
`else
    localparam bit TC_EN = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          run   = 1'b0;
    logic          step  = 1'b0;
    logic          rload = 1'b0;
    logic          clear = 1'b0;
    logic [NB-1:0] rval  = '0;
    logic          tick;
    logic          running;
    logic          done;
    logic [31:0]   tc;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit          rst;
        bit          run;
        bit          step;
        bit          rload;
        logic [NB-1:0] rval;
        bit          clear;
        bit          tick;
        bit          running;
        bit          done;
        int          tc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    logisim_tick_controller #(
        .NrOfBits     (NB),
        .DefaultReload(DEF)
    ) dut (
        .FPGAClock  (clk),
        .FPGAReset_n(rst_n),
        .Run        (run),
        .StepReq    (step),
        .ReloadLoad (rload),
        .ReloadValue(rval),
        .ClearCount (clear),
        .FPGATick   (tick),
        .Running    (running),
        .StepDone   (done),
        .TickCount  (tc)
    );

    always #5 clk = ~clk;

    function automatic void add(bit rs, bit r, bit s, bit rl, int rv,
                                bit cl, bit t, bit rn, bit d, int c);
        vec_t v;
        v.rst = rs; v.run = r; v.step = s; v.rload = rl;
        v.rval = NB'(rv); v.clear = cl;
        v.tick = t; v.running = rn; v.done = d; v.tc = c;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic wait_tick(output int n, input int budget);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (tick !== 1'b1 && n < budget);
        if (tick !== 1'b1) n = -1;
    endtask

    task automatic apply_all();
        vec_t v;
        vec_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            if (v.rst) begin
                run = 0; step = 0; rload = 0; clear = 0; rval = '0;
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            run = v.run; step = v.step; rload = v.rload;
            rval = v.rval; clear = v.clear;
            sb.push_back(v);
            @(posedge clk); #1;
            e = sb.pop_front();
            check($sformatf("v%0d.tick", i), 32'(tick), 32'(e.tick));
            check($sformatf("v%0d.running", i), 32'(running),
                  32'(e.running));
            check($sformatf("v%0d.done", i), 32'(done), 32'(e.done));
            if (e.tc >= 0)
                check($sformatf("v%0d.tc", i), tc,
                      TC_EN ? 32'(e.tc) : 32'd0);
        end
        @(negedge clk);
        run = 0; step = 0; rload = 0; clear = 0; rval = '0;
    endtask

    initial begin
        logic [31:0] mask_a;
        int c;

        // A: free run, reload to 2 mid-period, then to 0 (continuous)
        mask_a = 32'h01FA_A222;
        add(1, 1, 0, 0, 0, 0, 0, 1, 0, -1);
        for (int i = 1; i < 26; i++)
            add(0, i < 24, 0, (i == 10) || (i == 18), (i == 10) ? 2 : 0, 0,
                mask_a[i], i < 24, 0, -1);

        // B: single step, StepReq repeated while stepping is ignored
        add(1, 0, 1, 0, 0, 0, 0, 0, 0, -1);
        add(0, 0, 1, 0, 0, 0, 1, 0, 1, -1);
        for (int i = 0; i < 20; i++)
            add(0, 0, 0, 0, 0, 0, 0, 0, 0, -1);

        // C: Run beats StepReq, halt off-tick, rerun, step into run
        add(1, 1, 1, 0, 0, 0, 0, 1, 0, -1);
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, -1);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, -1);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, -1);
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, -1);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, -1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0, -1);
        add(0, 1, 0, 0, 0, 0, 1, 1, 1, -1);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, -1);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, -1);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, -1);
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, -1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, -1);

        // D: period 1 via reload in HALT, tick counter and clear
        add(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 3; i <= 13; i++)
            add(0, 1, 0, 0, 0, 0, 1, 1, 0, i - 3);
        add(0, 1, 0, 0, 0, 1, 1, 1, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1, 1, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);

        #1;
        check("rst.tick", 32'(tick), 32'd0);
        check("rst.running", 32'(running), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.tc", tc, 32'd0);

        apply_all();

        // E: async reset while ticking at period 2 restores DefaultReload
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        run = 1; rload = 1; rval = NB'(2);
        @(negedge clk);
        rload = 0; rval = '0;
        wait_tick(c, 10);
        wait_tick(c, 10);
        check("e.gap2", 32'(c), 32'd2);
        check("e.pre_running", 32'(running), 32'd1);
        check("e.pre_tick", 32'(tick), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("e.async_tick", 32'(tick), 32'd0);
        check("e.async_running", 32'(running), 32'd0);
        check("e.async_done", 32'(done), 32'd0);
        run = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("e.halt%0d", i), 32'({running, tick}), 32'd0);
        end
        @(negedge clk);
        run = 1;
        wait_tick(c, 10);
        check("e.first", 32'(c), 32'd2);
        wait_tick(c, 10);
        check("e.period", 32'(c), 32'(DEF));
        run = 0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
